// File: rtl/spike_window_capture_pkg.sv
// Shared types and helpers for the spike window capture block.
//   cap_state_e   : capture FSM state encoding
//   first_one_oh  : one-hot of the lowest set bit (earliest time step) of an
//                   LEN_REF-wide window, used as a reference model
package spike_pkg;

   localparam int unsigned LEN_REF = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      CAPTURE = 1'b1
   } cap_state_e;

   // Bit t holds time step t, so the earliest spike is the lowest set bit.
   function automatic logic [LEN_REF-1:0] first_one_oh(input logic [LEN_REF-1:0] vec);
      logic [LEN_REF-1:0] res;
      res = '0;
      for (int i = LEN_REF - 1; i >= 0; i--) begin
         if (vec[i]) begin
            res    = '0;
            res[i] = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/spike_window_capture_if.sv
// Output bus of the spike window capture block: captured window, earliest-spike
// marker and empty flag behind a valid/ready handshake.
//   vec_out   : captured window, bit t = time step t
//   first_oh  : one-hot earliest spike, same bit mapping, zero if none
//   no_spike  : window was empty
//   out_valid : payload valid
//   out_ready : consumer accepts on out_valid & out_ready
interface spike_window_capture_if #(
   parameter int unsigned LEN = 8
);
   logic [LEN-1:0] vec_out;
   logic [LEN-1:0] first_oh;
   logic           no_spike;
   logic           out_valid;
   logic           out_ready;

   modport master (
      output vec_out, first_oh, no_spike, out_valid,
      input  out_ready
   );

   modport slave (
      input  vec_out, first_oh, no_spike, out_valid,
      output out_ready
   );
endinterface

// File: rtl/spike_out_buf.sv
// One-entry valid/ready register slice holding a completed spike window.
//   clk, rst    : clock, async active-high reset
//   i_load_req  : a window completed this cycle
//   i_vec       : completed window vector
//   i_first     : completed window earliest-spike one-hot
//   o_overrun   : 1-cycle pulse when a completed window could not be stored
//   bus         : output payload and handshake (master side)
module spike_out_buf #(
   parameter int unsigned LEN = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_load_req,
   input  logic [LEN-1:0]         i_vec,
   input  logic [LEN-1:0]         i_first,
   output logic                   o_overrun,
   spike_window_capture_if.master bus
);

   logic           r_valid;
   logic [LEN-1:0] r_vec;
   logic [LEN-1:0] r_first;
   logic           r_no_spike;
   logic           r_overrun;
   logic           w_load;

   // Slot is free if empty or being drained this same cycle.
   assign w_load = i_load_req & (~r_valid | bus.out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_vec      <= '0;
         r_first    <= '0;
         r_no_spike <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= i_load_req & ~w_load;
         if (w_load) begin
            r_valid    <= 1'b1;
            r_vec      <= i_vec;
            r_first    <= i_first;
            r_no_spike <= (i_vec == '0);
         end else if (bus.out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_valid;
   assign bus.vec_out   = r_vec;
   assign bus.first_oh  = r_first;
   assign bus.no_spike  = r_no_spike;
   assign o_overrun     = r_overrun;

endmodule

// File: rtl/spike_window_capture.sv
// Deserialises a 1-bit spike line over a LEN-step window into a parallel
// vector plus a one-hot earliest-spike marker. Bit t of the vectors is time
// step t (value-compatible with the shifter's [0:LEN-1] index convention,
// where step t sits at index LEN-1-t).
//   clk, rst     : clock, async active-high reset
//   i_win_start  : start a window; this cycle is step 0
//   i_spike_in   : serial spike line
//   o_overrun    : completed window dropped because the output slot was full
//   o_busy       : window capture in progress
//   bus          : buffered window output with valid/ready handshake
module spike_window_capture #(
   parameter int unsigned LEN        = 8,
   parameter bit          CONTINUOUS = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_win_start,
   input  logic                   i_spike_in,
   output logic                   o_overrun,
   output logic                   o_busy,
   spike_window_capture_if.master bus
);
   import spike_pkg::*;

   localparam int unsigned     CNT_W = $clog2(LEN);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   cap_state_e     r_state;
   logic [CNT_W-1:0] r_count;
   logic [LEN-1:0] r_vec;
   logic [LEN-1:0] r_first;
   logic           r_busy;

   logic           w_sample;
   logic           w_done;
   logic [LEN-1:0] w_bit;
   logic [LEN-1:0] w_vec;
   logic [LEN-1:0] w_first;

   // The win_start cycle itself samples step 0; in CAPTURE win_start is moot.
   assign w_sample = (r_state == CAPTURE) | i_win_start;
   assign w_bit    = LEN'(i_spike_in) << r_count;
   assign w_vec    = r_vec | w_bit;
   // Earliest spike latches; later spikes leave it untouched.
   assign w_first  = (r_first != '0) ? r_first : w_bit;
   assign w_done   = w_sample & (r_count == LAST);

   // Capture FSM, step counter, shift register and first-spike tracker.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_vec   <= '0;
         r_first <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_win_start) begin
                  r_state <= CAPTURE;
                  r_busy  <= 1'b1;
                  r_count <= CNT_W'(1);
                  r_vec   <= w_vec;
                  r_first <= w_first;
               end
            end
            CAPTURE: begin
               if (w_done) begin
                  // Window handed to the buffer combinationally; clear for the next one.
                  r_count <= '0;
                  r_vec   <= '0;
                  r_first <= '0;
                  if (!CONTINUOUS) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_count <= r_count + CNT_W'(1);
                  r_vec   <= w_vec;
                  r_first <= w_first;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;

   spike_out_buf #(
      .LEN (LEN)
   ) u_out_buf (
      .clk        (clk),
      .rst        (rst),
      .i_load_req (w_done),
      .i_vec      (w_vec),
      .i_first    (w_first),
      .o_overrun  (o_overrun),
      .bus        (bus)
   );

endmodule

// File: tb/tb_spike_window_capture.sv
// Scoreboard bench for spike_window_capture: dut0 single-shot, dut1 continuous.
module tb_spike_window_capture;
   import spike_pkg::*;

   localparam int unsigned LEN = 8;

   typedef struct packed {
      logic [LEN-1:0] vec;
      logic [LEN-1:0] first;
      logic           nsp;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic ws0, sp0, ov0, busy0;
   logic ws1, sp1, ov1, busy1;

   int checks = 0;
   int errors = 0;
   int cyc1   = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e;
   exp_t obs0, obs1;
   logic [LEN-1:0] pats1 [4];

   always #5 clk = ~clk;

   spike_window_capture_if #(.LEN(LEN)) bus0 ();
   spike_window_capture_if #(.LEN(LEN)) bus1 ();

   spike_window_capture #(.LEN(LEN), .CONTINUOUS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .i_win_start(ws0), .i_spike_in(sp0),
      .o_overrun(ov0), .o_busy(busy0), .bus(bus0)
   );

   spike_window_capture #(.LEN(LEN), .CONTINUOUS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .i_win_start(ws1), .i_spike_in(sp1),
      .o_overrun(ov1), .o_busy(busy1), .bus(bus1)
   );

   assign obs0 = {bus0.vec_out, bus0.first_oh, bus0.no_spike};
   assign obs1 = {bus1.vec_out, bus1.first_oh, bus1.no_spike};

   function automatic exp_t mk(input logic [LEN-1:0] p);
      exp_t r;
      r.vec   = p;
      r.first = first_one_oh(p);
      r.nsp   = (p == '0);
      return r;
   endfunction

   // Drive one dut0 window; extra win_start pulse at step ws_extra (-1: none).
   task automatic drive_win0(input logic [LEN-1:0] p, input int ws_extra);
      for (int t = 0; t < int'(LEN); t++) begin
         ws0 = (t == 0) || (t == ws_extra);
         sp0 = p[t];
         @(posedge clk); #1;
      end
      ws0 = 1'b0;
      sp0 = 1'b0;
   endtask

   // One dut1 cycle following the continuous pattern timeline.
   task automatic step1();
      int k;
      k   = cyc1;
      ws1 = (k == 0);
      sp1 = (k < 32) ? pats1[k / 8][k % 8] : 1'b0;
      @(posedge clk); #1;
      cyc1++;
   endtask

   task automatic test_reset();
      rst = 1'b1; ws0 = 1'b0; sp0 = 1'b0; ws1 = 1'b0; sp1 = 1'b0;
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus0.out_valid); end
      checks++; if (obs0 !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", obs0); end
      checks++; if (ov0 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_ov_busy got %b%b exp 00", ov0, busy0); end
      checks++; if ({bus1.out_valid, ov1, busy1} !== 3'b000) begin errors++; $display("FAIL reset_dut1 got %b exp 000", {bus1.out_valid, ov1, busy1}); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      q0.push_back(mk(8'b0000_0010));
      drive_win0(8'b0000_0010, -1);
      checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL single_latency valid got %b exp 1", bus0.out_valid); end
      e = q0.pop_front();
      checks++; if (obs0 !== e) begin errors++; $display("FAIL single_out got %h exp %h", obs0, e); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", busy0); end
   endtask

   task automatic test_empty();
      q0.push_back(mk(8'h00));
      drive_win0(8'h00, -1);
      checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL empty_valid got %b exp 1", bus0.out_valid); end
      e = q0.pop_front();
      checks++; if (obs0 !== e) begin errors++; $display("FAIL empty_out got %h exp %h", obs0, e); end
   endtask

   task automatic test_union();
      q0.push_back(mk(8'b0110_0011));
      drive_win0(8'b0110_0011, 3);
      checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL union_valid got %b exp 1", bus0.out_valid); end
      e = q0.pop_front();
      checks++; if (obs0 !== e) begin errors++; $display("FAIL union_out got %h exp %h", obs0, e); end
   endtask

   task automatic test_backpressure();
      pats1[0] = 8'h81; pats1[1] = 8'h3C; pats1[2] = 8'h14; pats1[3] = 8'hA0;
      bus1.out_ready = 1'b0;
      q1.push_back(mk(pats1[0]));
      repeat (8) step1();
      checks++; if (bus1.out_valid !== 1'b1 || obs1 !== q1[0]) begin errors++; $display("FAIL bp_first got v=%b %h exp v=1 %h", bus1.out_valid, obs1, q1[0]); end
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL bp_no_overrun got %b exp 0", ov1); end
      for (int i = 0; i < 7; i++) begin
         step1();
         checks++; if ({bus1.out_valid, obs1} !== {1'b1, q1[0]}) begin errors++; $display("FAIL bp_hold cyc %0d got v=%b %h exp %h", cyc1, bus1.out_valid, obs1, q1[0]); end
      end
      step1();
      checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b exp 1", ov1); end
      checks++; if (obs1 !== q1[0]) begin errors++; $display("FAIL bp_after_drop got %h exp %h", obs1, q1[0]); end
      step1();
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL bp_overrun_pulse got %b exp 0", ov1); end
      step1();
      bus1.out_ready = 1'b1;
      e = q1.pop_front();
      checks++; if (obs1 !== e) begin errors++; $display("FAIL bp_accept got %h exp %h", obs1, e); end
      step1();
      checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain valid got %b exp 0", bus1.out_valid); end
      bus1.out_ready = 1'b0;
   endtask

   task automatic test_simul_accept_load();
      q1.push_back(mk(pats1[2]));
      q1.push_back(mk(pats1[3]));
      while (cyc1 < 24) step1();
      checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL sim_w3_valid got %b exp 1", bus1.out_valid); end
      while (cyc1 < 31) step1();
      bus1.out_ready = 1'b1;
      e = q1.pop_front();
      checks++; if (obs1 !== e) begin errors++; $display("FAIL sim_w3_out got %h exp %h", obs1, e); end
      step1();
      checks++; if ({bus1.out_valid, ov1} !== 2'b10) begin errors++; $display("FAIL sim_valid_ov got %b exp 10", {bus1.out_valid, ov1}); end
      e = q1.pop_front();
      checks++; if (obs1 !== e) begin errors++; $display("FAIL sim_w4_out got %h exp %h", obs1, e); end
      step1();
      checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL sim_drain valid got %b exp 0", bus1.out_valid); end
   endtask

   task automatic test_reset_mid();
      ws0 = 1'b1; sp0 = 1'b1; @(posedge clk); #1;
      ws0 = 1'b0; sp0 = 1'b0; @(posedge clk); #1;
      ws0 = 1'b1; sp0 = 1'b1; @(posedge clk); #1;
      ws0 = 1'b0; sp0 = 1'b0; @(posedge clk); #1;
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy0); end
      rst = 1'b1;
      #1;
      checks++; if ({bus0.out_valid, ov0, busy0} !== 3'b000) begin errors++; $display("FAIL mid_ctrl got %b exp 000", {bus0.out_valid, ov0, busy0}); end
      checks++; if (obs0 !== '0) begin errors++; $display("FAIL mid_out got %h exp 0", obs0); end
      checks++; if (obs1 !== '0 || busy1 !== 1'b0) begin errors++; $display("FAIL mid_dut1 got %h b=%b exp 0", obs1, busy1); end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_output got %b exp 0", bus0.out_valid); end
      q0.push_back(mk(8'b0100_1000));
      drive_win0(8'b0100_1000, -1);
      checks++; if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL fresh_valid got %b exp 1", bus0.out_valid); end
      e = q0.pop_front();
      checks++; if (obs0 !== e) begin errors++; $display("FAIL fresh_out got %h exp %h", obs0, e); end
      checks++; if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", q0.size() + q1.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_empty();
      test_union();
      test_backpressure();
      test_simul_accept_load();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
